// File: rtl/alu_steuerwerk.sv
// ALU issue and writeback controller: accepts one request over valid/ready,
// issues it to the ALU with a one-cycle start pulse, waits for completion
// (guarded by a watchdog) and presents the result toward writeback.
module alu_steuerwerk #(
  parameter int MAX_TAKTE   = 64,  // legal range 2..255
  parameter int ZIEL_BREITE = 5
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   AuftragGueltig,
  output logic                   AuftragBereit,
  input  logic [31:0]            AuftragDaten1,
  input  logic [31:0]            AuftragDaten2,
  input  logic [5:0]             AuftragFunktionsCode,
  input  logic [ZIEL_BREITE-1:0] AuftragZiel,
  output logic [31:0]            Daten1,
  output logic [31:0]            Daten2,
  output logic [5:0]             FunktionsCode,
  output logic                   StartSignal,
  input  logic                   HatFertigGerechnet,
  input  logic [31:0]            Ergebnis,
  output logic                   ErgebnisGueltig,
  input  logic                   ErgebnisBereit,
  output logic [31:0]            ErgebnisDaten,
  output logic [ZIEL_BREITE-1:0] ErgebnisZiel,
  output logic                   Zeitueberschreitung
);

  // One-hot encoding: each handshake output decodes to a single state flop,
  // so AuftragBereit, StartSignal and ErgebnisGueltig are glitch-free and
  // have no combinational path from any input.
  typedef enum logic [3:0] {
    LEERLAUF = 4'b0001,
    START    = 4'b0010,
    WARTEN   = 4'b0100,
    AUSGABE  = 4'b1000
  } zustandTyp;

  localparam logic [7:0] ZAEHLER_ENDE = 8'(MAX_TAKTE - 1);

  zustandTyp  zustand;
  zustandTyp  naechsterZustand;
  logic [7:0] waechterZaehler;
  logic       annahme;
  logic       fertig;
  logic       abgelaufen;

  // Qualified events; the completion flag only counts while waiting, which
  // also discards the stale flag the ALU shows during START.
  assign annahme    = (zustand == LEERLAUF) && AuftragGueltig;
  assign fertig     = (zustand == WARTEN) && HatFertigGerechnet;
  assign abgelaufen = (zustand == WARTEN) && !HatFertigGerechnet &&
                      (waechterZaehler == ZAEHLER_ENDE);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) zustand <= LEERLAUF;
    else       zustand <= naechsterZustand;
  end

  // Next-state logic; completion wins over timeout because fertig is tested first.
  // NOTE: the default assignment at the top keeps every path assigned, so no
  // latch is inferred when a branch does not change the state.
  always_comb begin
    naechsterZustand = zustand;
    unique case (zustand)
      LEERLAUF: if (annahme)                naechsterZustand = START;
      START:                                naechsterZustand = WARTEN;
      WARTEN:   if (fertig || abgelaufen)   naechsterZustand = AUSGABE;
      AUSGABE:  if (ErgebnisBereit)         naechsterZustand = LEERLAUF;
      default:                              naechsterZustand = LEERLAUF;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    AuftragBereit   = (zustand == LEERLAUF);
    StartSignal     = (zustand == START);
    ErgebnisGueltig = (zustand == AUSGABE);
  end

  // Operand capture; the ALU inputs stay frozen until the next acceptance.
  // NOTE: every datapath register is reset, so a mid-operation reset leaves
  // no stale operands on the ALU bus or stale result toward writeback.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Daten1        <= '0;
      Daten2        <= '0;
      FunktionsCode <= '0;
      ErgebnisZiel  <= '0;
    end else if (annahme) begin
      Daten1        <= AuftragDaten1;
      Daten2        <= AuftragDaten2;
      FunktionsCode <= AuftragFunktionsCode;
      ErgebnisZiel  <= AuftragZiel;
    end
  end

  // Watchdog: cleared in START, counts idle WARTEN cycles, saturates at the limit.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      waechterZaehler <= '0;
    end else if (zustand == START) begin
      waechterZaehler <= '0;
    end else if ((zustand == WARTEN) && !HatFertigGerechnet &&
                 (waechterZaehler != ZAEHLER_ENDE)) begin
      waechterZaehler <= waechterZaehler + 8'd1;
    end
  end

  // Result capture: ALU result on completion, zero plus timeout flag on abort.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ErgebnisDaten       <= '0;
      Zeitueberschreitung <= 1'b0;
    end else if (fertig) begin
      ErgebnisDaten       <= Ergebnis;
      Zeitueberschreitung <= 1'b0;
    end else if (abgelaufen) begin
      ErgebnisDaten       <= '0;
      Zeitueberschreitung <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_steuerwerk.sv
// Self-checking bench for alu_steuerwerk: directed vector table, hand-written
// back-to-back and reset sequences, and randomized requests against a
// latency/result prediction derived from the controller's timing rules.
module tb_alu_steuerwerk;

  localparam int MAX = 16;

  logic        Clock;
  logic        Reset;
  logic        AuftragGueltig;
  logic        AuftragBereit;
  logic [31:0] AuftragDaten1;
  logic [31:0] AuftragDaten2;
  logic [5:0]  AuftragFunktionsCode;
  logic [4:0]  AuftragZiel;
  logic [31:0] Daten1;
  logic [31:0] Daten2;
  logic [5:0]  FunktionsCode;
  logic        StartSignal;
  logic        HatFertigGerechnet;
  logic [31:0] Ergebnis;
  logic        ErgebnisGueltig;
  logic        ErgebnisBereit;
  logic [31:0] ErgebnisDaten;
  logic [4:0]  ErgebnisZiel;
  logic        Zeitueberschreitung;

  alu_steuerwerk #(.MAX_TAKTE(MAX), .ZIEL_BREITE(5)) dut (
    .Clock(Clock), .Reset(Reset),
    .AuftragGueltig(AuftragGueltig), .AuftragBereit(AuftragBereit),
    .AuftragDaten1(AuftragDaten1), .AuftragDaten2(AuftragDaten2),
    .AuftragFunktionsCode(AuftragFunktionsCode), .AuftragZiel(AuftragZiel),
    .Daten1(Daten1), .Daten2(Daten2), .FunktionsCode(FunktionsCode),
    .StartSignal(StartSignal), .HatFertigGerechnet(HatFertigGerechnet),
    .Ergebnis(Ergebnis), .ErgebnisGueltig(ErgebnisGueltig),
    .ErgebnisBereit(ErgebnisBereit), .ErgebnisDaten(ErgebnisDaten),
    .ErgebnisZiel(ErgebnisZiel), .Zeitueberschreitung(Zeitueberschreitung)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int startCount = 0;
  int lastStart = -1;

  always @(posedge Clock) cyc <= cyc + 1;

  // Start-pulse monitor, sampled mid-cycle.
  always @(negedge Clock) begin
    if (StartSignal) begin
      startCount = startCount + 1;
      lastStart = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] ist, input logic [31:0] soll);
    total++;
    if (ist !== soll) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, ist, soll);
    end
  endtask

  // ---------------- ALU model (stimulus side) ----------------
  function automatic bit [31:0] aluFunktion(input bit [5:0] op, input bit [31:0] a, input bit [31:0] b);
    case (op)
      6'h00: return a + b;
      6'h01: return a - b;
      6'h02: return a & b;
      6'h03: return a | b;
      6'h13: return a ^ b;
      6'h04: return (b == 0) ? 32'hFFFFFFFF : a / b;
      6'h05: return (b == 0) ? a : a % b;
      6'h20: return (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : 32'h7FC00000;
      6'h23: return 32'h3F000000;
      default: return 32'h0;
    endcase
  endfunction

  int      aluK = 0;
  int      aluRest = 0;
  bit      aluAktiv = 0;
  bit      aluHang = 0;
  bit      aluStale = 0;
  bit [31:0] aluErgebnis = 0;

  assign HatFertigGerechnet = aluStale || (aluAktiv && (aluRest == 0) && !aluHang);
  assign Ergebnis = aluErgebnis;

  // ALU latency countdown: loads on the start pulse, flags done for one cycle.
  always @(posedge Clock) begin
    if (StartSignal) begin
      aluAktiv    <= 1'b1;
      aluRest     <= aluK;
      aluErgebnis <= aluFunktion(FunktionsCode, Daten1, Daten2);
    end else if (aluAktiv) begin
      if (aluRest == 0) aluAktiv <= 1'b0;
      else              aluRest  <= aluRest - 1;
    end
  end

  // ---------------- vectors and reference ----------------
  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    int          k;
    bit          hang;
    bit          stale;
    int          delay;
    logic [31:0] expData;
    bit          expTo;
    int          expLat;
  } vecTyp;

  // Reference: completion at WARTEN cycle k wins if it happens no later than
  // the last watchdog cycle (index MAX-1); otherwise the op times out.
  function automatic vecTyp vorhersage(input vecTyp v);
    vecTyp r = v;
    if (v.hang || v.k > MAX - 1) begin
      r.expTo = 1'b1; r.expData = 32'h0; r.expLat = 2 + MAX;
    end else begin
      r.expTo = 1'b0; r.expData = aluFunktion(v.op, v.a, v.b); r.expLat = 3 + v.k;
    end
    return r;
  endfunction

  task automatic runVec(input vecTyp v);
    int n, w, s0;
    w = 0;
    while (!AuftragBereit && w < 100) begin @(negedge Clock); w++; end
    check("wait_ready", 32'(w < 100), 1);
    AuftragGueltig = 1; AuftragDaten1 = v.a; AuftragDaten2 = v.b;
    AuftragFunktionsCode = v.op; AuftragZiel = v.tag;
    aluK = v.k; aluHang = v.hang;
    ErgebnisBereit = (v.delay == 0);
    n = cyc; s0 = startCount;
    @(negedge Clock);
    AuftragGueltig = 0;
    check("start_n1", StartSignal, 1);
    check("bereit_in_start", AuftragBereit, 0);
    if (v.stale) aluStale = 1;
    @(negedge Clock);
    aluStale = 0;
    check("start_n2", StartSignal, 0);
    w = 0;
    while (!ErgebnisGueltig && w < 300) begin @(negedge Clock); w++; end
    check("wait_valid", 32'(w < 300), 1);
    check("latency", 32'(cyc - n), 32'(v.expLat));
    check("data", ErgebnisDaten, v.expData);
    check("tag", ErgebnisZiel, v.tag);
    check("timeout", Zeitueberschreitung, v.expTo);
    check("alu_d1", Daten1, v.a);
    check("alu_d2", Daten2, v.b);
    check("alu_fc", FunktionsCode, v.op);
    check("single_start", 32'(startCount - s0), 1);
    check("start_cycle", 32'(lastStart), 32'(n + 1));
    for (int i = 0; i < v.delay; i++) begin
      @(negedge Clock);
      check("hold_valid", ErgebnisGueltig, 1);
      check("hold_data", ErgebnisDaten, v.expData);
      check("hold_tag", ErgebnisZiel, v.tag);
      check("hold_bereit", AuftragBereit, 0);
    end
    ErgebnisBereit = 1;
    @(negedge Clock);
    check("ready_after", AuftragBereit, 1);
    check("valid_dropped", ErgebnisGueltig, 0);
  endtask

  // Global bound on simulation time.
  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vecTyp tabelle[7];
    vecTyp r;
    bit [5:0] ops[7];
    int n, s0;

    tabelle[0] = '{6'h00, 32'd5, 32'd7, 5'd3, 0, 0, 0, 0, 32'd12, 0, 3};
    tabelle[1] = '{6'h20, 32'h3F800000, 32'h40000000, 5'd6, 6, 0, 0, 5, 32'h40400000, 0, 9};
    tabelle[2] = '{6'h04, 32'd100, 32'd7, 5'd11, 10, 0, 1, 0, 32'd14, 0, 13};
    tabelle[3] = '{6'h00, 32'd1, 32'd1, 5'd20, 0, 1, 0, 0, 32'd0, 1, 18};
    tabelle[4] = '{6'h00, 32'd2, 32'd3, 5'd21, 0, 0, 0, 0, 32'd5, 0, 3};
    tabelle[5] = '{6'h13, 32'hAAAA5555, 32'hFFFF0000, 5'd14, 15, 0, 0, 1, 32'h55555555, 0, 18};
    tabelle[6] = '{6'h01, 32'd10, 32'd3, 5'd31, 16, 0, 0, 0, 32'd0, 1, 18};
    ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h13, 6'h04, 6'h05};

    Reset = 1; AuftragGueltig = 0; AuftragDaten1 = 0; AuftragDaten2 = 0;
    AuftragFunktionsCode = 0; AuftragZiel = 0; ErgebnisBereit = 0;
    repeat (2) @(negedge Clock);
    check("rst_bereit", AuftragBereit, 1);
    check("rst_start", StartSignal, 0);
    check("rst_valid", ErgebnisGueltig, 0);
    check("rst_to", Zeitueberschreitung, 0);
    check("rst_d1", Daten1, 0);
    check("rst_d2", Daten2, 0);
    check("rst_fc", FunktionsCode, 0);
    check("rst_data", ErgebnisDaten, 0);
    check("rst_tag", ErgebnisZiel, 0);
    Reset = 0;
    @(negedge Clock);
    check("post_rst_start", StartSignal, 0);
    check("post_rst_count", 32'(startCount), 0);

    for (int i = 0; i < 7; i++) runVec(tabelle[i]);

    // Back-to-back: valid held high, second request staged while busy.
    while (!AuftragBereit) @(negedge Clock);
    AuftragGueltig = 1; AuftragDaten1 = 32'h11111111; AuftragDaten2 = 32'h22222222;
    AuftragFunktionsCode = 6'h00; AuftragZiel = 5'd7; aluK = 0; aluHang = 0;
    ErgebnisBereit = 1; n = cyc; s0 = startCount;
    repeat (3) @(negedge Clock);
    check("b2b_valid1", ErgebnisGueltig, 1);
    check("b2b_data1", ErgebnisDaten, 32'h33333333);
    check("b2b_tag1", ErgebnisZiel, 5'd7);
    AuftragDaten1 = 32'hF0F0F0F0; AuftragDaten2 = 32'hFFFF0000;
    AuftragFunktionsCode = 6'h13; AuftragZiel = 5'd9;
    @(negedge Clock);
    check("b2b_bereit", AuftragBereit, 1);
    check("b2b_no_double", 32'(startCount - s0), 1);
    @(negedge Clock);
    AuftragGueltig = 0;
    repeat (2) @(negedge Clock);
    check("b2b_valid2", ErgebnisGueltig, 1);
    check("b2b_spacing", 32'(cyc - n), 7);
    check("b2b_data2", ErgebnisDaten, 32'h0F0FF0F0);
    check("b2b_tag2", ErgebnisZiel, 5'd9);
    check("b2b_starts", 32'(startCount - s0), 2);
    check("b2b_start2_cycle", 32'(lastStart), 32'(n + 5));
    @(negedge Clock);

    // Reset in the middle of a long float divide.
    while (!AuftragBereit) @(negedge Clock);
    AuftragGueltig = 1; AuftragDaten1 = 32'h3F800000; AuftragDaten2 = 32'h40000000;
    AuftragFunktionsCode = 6'h23; AuftragZiel = 5'd9; aluK = 31; ErgebnisBereit = 1;
    @(negedge Clock);
    AuftragGueltig = 0;
    repeat (4) @(negedge Clock);
    check("mid_not_done", ErgebnisGueltig, 0);
    #2 Reset = 1;
    #1;
    check("arst_bereit", AuftragBereit, 1);
    check("arst_start", StartSignal, 0);
    check("arst_valid", ErgebnisGueltig, 0);
    check("arst_to", Zeitueberschreitung, 0);
    check("arst_d1", Daten1, 0);
    check("arst_d2", Daten2, 0);
    check("arst_fc", FunktionsCode, 0);
    check("arst_data", ErgebnisDaten, 0);
    check("arst_tag", ErgebnisZiel, 0);
    @(negedge Clock);
    Reset = 0;
    s0 = startCount;
    @(negedge Clock);
    check("arst_no_start", StartSignal, 0);
    check("arst_no_count", 32'(startCount - s0), 0);
    runVec(tabelle[0]);

    // Randomized requests against the reference prediction.
    for (int i = 0; i < 25; i++) begin
      r.op = ops[$urandom_range(0, 6)];
      r.a = $urandom;
      r.b = (r.op == 6'h04 || r.op == 6'h05) ? 32'($urandom_range(1, 1000)) : $urandom;
      r.tag = 5'($urandom);
      r.k = $urandom_range(0, 18);
      r.hang = ($urandom_range(0, 9) == 0);
      r.stale = 1'($urandom_range(0, 1));
      r.delay = $urandom_range(0, 3);
      runVec(vorhersage(r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
